// File: rtl/ins_fetch_sequencer_pkg.sv
// Shared constants and state encoding for the bb_core instruction-fetch sequencer.
package ins_fetch_sequencer_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/ins_fetch_sequencer.sv
// Instruction-fetch controller: PC strobes, req/ack memory reads, one-entry
// instruction buffer, and jump redirect with squash of stale fetches.
module ins_fetch_sequencer
  import ins_fetch_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_run,
  input  logic                  i_jump_en,
  input  logic [DATA_WIDTH-1:0] i_jump_addr,
  input  logic [DATA_WIDTH-1:0] i_pc,
  output logic                  o_pc_oen,
  output logic                  o_pc_ien,
  output logic [DATA_WIDTH-1:0] o_dir_addr,
  output logic                  o_mem_req,
  output logic [DATA_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_ack,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_ins_valid,
  output logic [DATA_WIDTH-1:0] o_ins,
  input  logic                  i_ins_ready
);

  state_t                state_q, state_d;
  logic                  jmp_pend_q, jmp_pend_d;
  logic [DATA_WIDTH-1:0] jmp_tgt_q, jmp_tgt_d;
  logic                  squash_q, squash_d;
  logic                  gap_q, gap_d;
  logic                  req_jmp_q, req_jmp_d;
  logic [DATA_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0] ins_buf_q, ins_buf_d;
  logic                  enter_fetch;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      jmp_pend_q <= 1'b0;
      jmp_tgt_q  <= '0;
      squash_q   <= 1'b0;
      gap_q      <= 1'b0;
      req_jmp_q  <= 1'b0;
      req_addr_q <= '0;
      ins_buf_q  <= '0;
    end else begin
      state_q    <= state_d;
      jmp_pend_q <= jmp_pend_d;
      jmp_tgt_q  <= jmp_tgt_d;
      squash_q   <= squash_d;
      gap_q      <= gap_d;
      req_jmp_q  <= req_jmp_d;
      req_addr_q <= req_addr_d;
      ins_buf_q  <= ins_buf_d;
    end
  end

  // Next-state and PC strobes
  always_comb begin
    state_d     = state_q;
    jmp_pend_d  = jmp_pend_q;
    jmp_tgt_d   = jmp_tgt_q;
    squash_d    = squash_q;
    gap_d       = gap_q;
    req_jmp_d   = req_jmp_q;
    req_addr_d  = req_addr_q;
    ins_buf_d   = ins_buf_q;
    enter_fetch = 1'b0;
    o_pc_oen    = 1'b0;
    o_pc_ien    = 1'b0;

    if (i_jump_en) begin
      jmp_pend_d = 1'b1;
      jmp_tgt_d  = i_jump_addr;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_run) begin
          state_d     = ST_FETCH;
          enter_fetch = 1'b1;
        end
      end
      ST_FETCH: begin
        if (gap_q) begin
          // Request idle for one cycle; re-aim at the latest jump target
          gap_d      = 1'b0;
          req_addr_d = jmp_tgt_d;
          req_jmp_d  = 1'b1;
        end else if (i_mem_ack) begin
          if (squash_q || i_jump_en) begin
            squash_d = 1'b0;
            gap_d    = 1'b1;
          end else begin
            ins_buf_d = i_mem_rdata;
            state_d   = ST_FULL;
            if (req_jmp_q) begin
              o_pc_ien   = 1'b1;
              jmp_pend_d = 1'b0;
            end else begin
              o_pc_oen = 1'b1;
            end
          end
        end else if (i_jump_en) begin
          squash_d = 1'b1;
        end
      end
      ST_FULL: begin
        if (i_jump_en || i_ins_ready) begin
          if (i_run) begin
            state_d     = ST_FETCH;
            enter_fetch = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A jump arriving on the entry cycle already redirects this fetch
    if (enter_fetch) begin
      req_addr_d = jmp_pend_d ? jmp_tgt_d : i_pc;
      req_jmp_d  = jmp_pend_d;
    end
  end

  assign o_mem_req   = (state_q == ST_FETCH) && !gap_q;
  assign o_mem_addr  = req_addr_q;
  assign o_ins_valid = (state_q == ST_FULL);
  assign o_ins       = ins_buf_q;
  assign o_dir_addr  = jmp_tgt_q;

endmodule

// File: tb/tb_ins_fetch_sequencer.sv
// Directed vector bench for ins_fetch_sequencer with a behavioural PC unit.
module tb_ins_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_run;
  logic       i_jump_en;
  logic [7:0] i_jump_addr;
  logic [7:0] i_pc = 8'h00;
  logic       o_pc_oen;
  logic       o_pc_ien;
  logic [7:0] o_dir_addr;
  logic       o_mem_req;
  logic [7:0] o_mem_addr;
  logic       i_mem_ack;
  logic [7:0] i_mem_rdata;
  logic       o_ins_valid;
  logic [7:0] o_ins;
  logic       i_ins_ready;

  int total = 0;
  int bad   = 0;

  ins_fetch_sequencer #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_run      (i_run),
    .i_jump_en  (i_jump_en),
    .i_jump_addr(i_jump_addr),
    .i_pc       (i_pc),
    .o_pc_oen   (o_pc_oen),
    .o_pc_ien   (o_pc_ien),
    .o_dir_addr (o_dir_addr),
    .o_mem_req  (o_mem_req),
    .o_mem_addr (o_mem_addr),
    .i_mem_ack  (i_mem_ack),
    .i_mem_rdata(i_mem_rdata),
    .o_ins_valid(o_ins_valid),
    .o_ins      (o_ins),
    .i_ins_ready(i_ins_ready)
  );

  always #5 clk = ~clk;

  // PC unit: increment on oen, load target then hold target+1 on ien
  always @(posedge clk) begin
    if (o_pc_oen)      i_pc <= i_pc + 8'd1;
    else if (o_pc_ien) i_pc <= o_dir_addr + 8'd1;
  end

  typedef struct {
    logic        rst, run, jen;
    logic [7:0]  jaddr;
    logic        ack;
    logic [7:0]  rdata;
    logic        rdy;
    logic [27:0] exp; // {req, maddr, oen, ien, dir, valid, ins}
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t v(input logic rst, input logic run, input logic jen,
                             input logic [7:0] jaddr, input logic ack,
                             input logic [7:0] rdata, input logic rdy,
                             input logic req, input logic [7:0] maddr,
                             input logic oen, input logic ien, input logic [7:0] dir,
                             input logic valid, input logic [7:0] ins);
    vec_t r;
    r.rst = rst; r.run = run; r.jen = jen; r.jaddr = jaddr;
    r.ack = ack; r.rdata = rdata; r.rdy = rdy;
    r.exp = {req, maddr, oen, ien, dir, valid, ins};
    return r;
  endfunction

  function automatic logic [27:0] outs();
    return {o_mem_req, o_mem_addr, o_pc_oen, o_pc_ien, o_dir_addr, o_ins_valid, o_ins};
  endfunction

  task automatic drive(input logic rst, input logic run, input logic jen,
                       input logic [7:0] jaddr, input logic ack,
                       input logic [7:0] rdata, input logic rdy);
    @(negedge clk);
    rst_n = rst; i_run = run; i_jump_en = jen; i_jump_addr = jaddr;
    i_mem_ack = ack; i_mem_rdata = rdata; i_ins_ready = rdy;
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; i_run = 1'b0; i_jump_en = 1'b0; i_jump_addr = 8'h00;
    i_mem_ack = 1'b0; i_mem_rdata = 8'h00; i_ins_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset, straight-line fetch, jump from FULL, delayed-ack squash, run drop
    vecs[0]  = v(0,0,0,8'h00,0,8'h00,0, 0,8'h00,0,0,8'h00,0,8'h00);
    vecs[1]  = v(1,1,0,8'h00,0,8'h00,0, 0,8'h00,0,0,8'h00,0,8'h00);
    vecs[2]  = v(1,1,0,8'h00,1,8'hA0,1, 1,8'h00,1,0,8'h00,0,8'h00);
    vecs[3]  = v(1,1,0,8'h00,0,8'h00,1, 0,8'h00,0,0,8'h00,1,8'hA0);
    vecs[4]  = v(1,1,0,8'h00,1,8'hA1,1, 1,8'h01,1,0,8'h00,0,8'hA0);
    vecs[5]  = v(1,1,0,8'h00,0,8'h00,1, 0,8'h01,0,0,8'h00,1,8'hA1);
    vecs[6]  = v(1,1,0,8'h00,1,8'hA2,1, 1,8'h02,1,0,8'h00,0,8'hA1);
    vecs[7]  = v(1,1,0,8'h00,0,8'h00,0, 0,8'h02,0,0,8'h00,1,8'hA2);
    vecs[8]  = v(1,1,1,8'h40,0,8'h00,0, 0,8'h02,0,0,8'h00,1,8'hA2);
    vecs[9]  = v(1,1,0,8'h00,0,8'h00,0, 1,8'h40,0,0,8'h40,0,8'hA2);
    vecs[10] = v(1,1,0,8'h00,1,8'hC0,0, 1,8'h40,0,1,8'h40,0,8'hA2);
    vecs[11] = v(1,1,0,8'h00,0,8'h00,1, 0,8'h40,0,0,8'h40,1,8'hC0);
    vecs[12] = v(1,1,0,8'h00,0,8'h00,0, 1,8'h41,0,0,8'h40,0,8'hC0);
    vecs[13] = v(1,1,1,8'h30,0,8'h00,0, 1,8'h41,0,0,8'h40,0,8'hC0);
    vecs[14] = v(1,1,0,8'h00,0,8'h00,0, 1,8'h41,0,0,8'h30,0,8'hC0);
    vecs[15] = v(1,1,0,8'h00,0,8'h00,0, 1,8'h41,0,0,8'h30,0,8'hC0);
    vecs[16] = v(1,1,0,8'h00,1,8'h99,0, 1,8'h41,0,0,8'h30,0,8'hC0);
    vecs[17] = v(1,1,0,8'h00,0,8'h00,0, 0,8'h41,0,0,8'h30,0,8'hC0);
    vecs[18] = v(1,1,0,8'h00,1,8'hB0,0, 1,8'h30,0,1,8'h30,0,8'hC0);
    vecs[19] = v(1,0,0,8'h00,0,8'h00,1, 0,8'h30,0,0,8'h30,1,8'hB0);
    vecs[20] = v(1,0,0,8'h00,0,8'h00,0, 0,8'h30,0,0,8'h30,0,8'hB0);

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].rst, vecs[i].run, vecs[i].jen, vecs[i].jaddr,
            vecs[i].ack, vecs[i].rdata, vecs[i].rdy);
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end

    // Backpressure: buffer held for 5 cycles, release fetches from pc+1
    drive(1,1,0,8'h00,0,8'h00,0);
    chk("bp_idle_req", 32'(o_mem_req), 32'd0);
    drive(1,1,0,8'h00,1,8'hD1,0);
    chk("bp_fetch", 32'({o_mem_addr, o_pc_oen}), 32'({8'h31, 1'b1}));
    for (int k = 0; k < 5; k++) begin
      drive(1,1,0,8'h00,0,8'h00,0);
      chk($sformatf("bp_hold%0d", k), 32'({o_ins_valid, o_ins, o_mem_req}),
          32'({1'b1, 8'hD1, 1'b0}));
    end
    drive(1,1,0,8'h00,0,8'h00,1);
    drive(1,1,0,8'h00,0,8'h00,0);
    chk("bp_next_req", 32'({o_mem_req, o_mem_addr}), 32'({1'b1, 8'h32}));

    // Two jumps back to back in FETCH: only the last target is fetched
    drive(1,1,1,8'h10,0,8'h00,0);
    drive(1,1,1,8'h20,0,8'h00,0);
    chk("jj_first_tgt", 32'(o_dir_addr), 32'h10);
    drive(1,1,0,8'h00,1,8'h77,0);
    chk("jj_stale_ack", 32'({o_pc_oen, o_pc_ien}), 32'd0);
    drive(1,1,0,8'h00,0,8'h00,0);
    chk("jj_gap", 32'(o_mem_req), 32'd0);
    drive(1,1,0,8'h00,1,8'hE0,0);
    chk("jj_redirect", 32'({o_mem_req, o_mem_addr, o_pc_ien, o_dir_addr}),
        32'({1'b1, 8'h20, 1'b1, 8'h20}));
    drive(1,1,0,8'h00,0,8'h00,1);
    chk("jj_buf", 32'({o_ins_valid, o_ins}), 32'({1'b1, 8'hE0}));

    // Reset mid-request with a pending jump; restart fetches from i_pc
    drive(1,1,1,8'h55,0,8'h00,0);
    chk("rst_pre_req", 32'({o_mem_req, o_mem_addr}), 32'({1'b1, 8'h21}));
    drive(0,1,0,8'h00,0,8'h00,0);
    drive(1,1,0,8'h00,0,8'h00,0);
    chk("rst_outputs", 32'(outs()), 32'd0);
    drive(1,1,0,8'h00,0,8'h00,0);
    chk("rst_restart", 32'({o_mem_req, o_mem_addr}), 32'({1'b1, 8'h21}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
